// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width defaults, R_W direction encodings and the
// memory-interface FSM state encoding.
package cpu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Request-timeout counter: cleared outside REQ, counts each REQ cycle and
// flags expiry during the TMO_CYC-th consecutive cycle.
module mem_timeout_ctr #(
   parameter int TMO_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = (cnt_q == CW'(TMO_CYC - 1));

   // Next count; saturates at the expiry value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (en && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_bus_interface.sv
// Memory-side stage: owns MAR/MDR and turns controller strobes into a req/ack
// memory handshake. Optional request timeout with sticky bus_err under MEM_TIMEOUT_EN.
module mem_bus_interface
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TMO_CYC = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LDmar,
   input  logic              LDmdr,
   input  logic              MM,
   input  logic              R_W,
   input  logic              TMDR,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_done,
   output logic              busy,
   output logic              bus_err
);

   mem_state_e        state_q, state_d;
   logic              dir_q, dir_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              bus_err_q, bus_err_d;
   logic              tmo_s;
   logic              in_req_s;

   assign in_req_s = (state_q == S_REQ);

`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (!in_req_s),
      .en      (in_req_s),
      .expired (tmo_s)
   );
`else
   logic [31:0] tmo_unused_s;
   assign tmo_unused_s = TMO_CYC;
   assign tmo_s        = 1'b0;
`endif

   // Outputs decode straight from registered state so reset drops them at once.
   assign mem_req   = in_req_s;
   assign mem_we    = in_req_s && (dir_q == RW_WRITE);
   assign mem_done  = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign bus_err   = bus_err_q;
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign bus_out   = TMDR ? mdr_q : {DATA_W{1'b0}};

   // Next-state and register-load logic; MAR/MDR only load from the bus while idle.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      mar_d     = mar_q;
      mdr_d     = mdr_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE: begin
            if (LDmar) begin
               mar_d = bus_in[ADDR_W-1:0];
            end else begin
               mar_d = mar_q;
            end
            if (LDmdr) begin
               mdr_d = bus_in;
            end else begin
               mdr_d = mdr_q;
            end
            if (MM) begin
               state_d = S_REQ;
               dir_d   = R_W;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_DONE;
               if (dir_q == RW_READ) begin
                  mdr_d = mem_rdata;
               end else begin
                  mdr_d = mdr_q;
               end
            end else if (tmo_s) begin
               state_d   = S_DONE;
               bus_err_d = 1'b1;
            end else begin
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dir_q     <= RW_WRITE;
         mar_q     <= {ADDR_W{1'b0}};
         mdr_q     <= {DATA_W{1'b0}};
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         bus_err_q <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed self-checking bench for mem_bus_interface; timeout checks follow MEM_TIMEOUT_EN.
module tb_mem_bus_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic        LDmar, LDmdr, MM, R_W, TMDR;
   logic [15:0] bus_in;
   logic [15:0] bus_out;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_done, busy, bus_err;

   int total = 0;
   int bad   = 0;

   mem_bus_interface dut (
      .clk       (clk),
      .rst       (rst),
      .LDmar     (LDmar),
      .LDmdr     (LDmdr),
      .MM        (MM),
      .R_W       (R_W),
      .TMDR      (TMDR),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_done  (mem_done),
      .busy      (busy),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      LDmar = 1'b0; LDmdr = 1'b0; MM = 1'b0; R_W = 1'b0; TMDR = 1'b0;
      bus_in = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #12;
      chk("rst_req",  {31'd0, mem_req},  32'd0);
      chk("rst_we",   {31'd0, mem_we},   32'd0);
      chk("rst_done", {31'd0, mem_done}, 32'd0);
      chk("rst_busy", {31'd0, busy},     32'd0);
      chk("rst_err",  {31'd0, bus_err},  32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'd0);
      rst = 1'b0;
      tick();

      // Write: load MAR, load MDR, start, ack after 3 REQ cycles
      LDmar = 1'b1; bus_in = 16'h0040; tick();
      LDmar = 1'b0; LDmdr = 1'b1; bus_in = 16'hBEEF; tick();
      LDmdr = 1'b0; MM = 1'b1; R_W = 1'b0; bus_in = 16'h0000; tick();
      MM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wr_req",   {31'd0, mem_req},   32'd1);
         chk("wr_we",    {31'd0, mem_we},    32'd1);
         chk("wr_addr",  {16'd0, mem_addr},  32'h0040);
         chk("wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
         chk("wr_nodone", {31'd0, mem_done}, 32'd0);
         if (i == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      chk("wr_done",   {31'd0, mem_done}, 32'd1);
      chk("wr_req_lo", {31'd0, mem_req},  32'd0);
      chk("wr_busy",   {31'd0, busy},     32'd1);
      tick();
      chk("wr_done_1", {31'd0, mem_done}, 32'd0);
      chk("wr_idle",   {31'd0, busy},     32'd0);

      // Read with ack in the first REQ cycle
      LDmar = 1'b1; bus_in = 16'h0041; tick();
      LDmar = 1'b0; MM = 1'b1; R_W = 1'b1; tick();
      MM = 1'b0; R_W = 1'b0;
      chk("rd_req",  {31'd0, mem_req},  32'd1);
      chk("rd_we",   {31'd0, mem_we},   32'd0);
      chk("rd_addr", {16'd0, mem_addr}, 32'h0041);
      mem_ack = 1'b1; mem_rdata = 16'h1234; tick();
      mem_ack = 1'b0; mem_rdata = 16'h0000;
      chk("rd_done", {31'd0, mem_done}, 32'd1);
      TMDR = 1'b1; #1;
      chk("rd_busout", {16'd0, bus_out}, 32'h1234);
      TMDR = 1'b0; #1;
      chk("busout_off", {16'd0, bus_out}, 32'h0000);
      tick();

      // Collisions: MM/LDmar while busy, stray ack in IDLE
      MM = 1'b1; R_W = 1'b0; tick();
      LDmar = 1'b1; bus_in = 16'h0099; R_W = 1'b1; tick();
      LDmar = 1'b0; MM = 1'b0;
      chk("col_addr", {16'd0, mem_addr}, 32'h0041);
      chk("col_we",   {31'd0, mem_we},   32'd1);
      mem_ack = 1'b1; tick();
      mem_ack = 1'b0; MM = 1'b1;
      chk("col_done", {31'd0, mem_done}, 32'd1);
      chk("col_mdr",  {16'd0, mem_wdata}, 32'h1234);
      tick();
      MM = 1'b0;
      chk("col_noreq",  {31'd0, mem_req},  32'd0);
      chk("col_nobusy", {31'd0, busy},     32'd0);
      mem_ack = 1'b1; tick();
      mem_ack = 1'b0;
      chk("stray_req",  {31'd0, mem_req},  32'd0);
      tick();
      chk("stray_done", {31'd0, mem_done}, 32'd0);

      // Same-cycle LDmdr + MM write
      LDmdr = 1'b1; bus_in = 16'h00AA; MM = 1'b1; R_W = 1'b0; tick();
      LDmdr = 1'b0; MM = 1'b0; bus_in = 16'h0000;
      chk("same_req",   {31'd0, mem_req},   32'd1);
      chk("same_wdata", {16'd0, mem_wdata}, 32'h00AA);
      tick();
      chk("same_wdata2", {16'd0, mem_wdata}, 32'h00AA);
      mem_ack = 1'b1; tick();
      mem_ack = 1'b0;
      chk("same_done", {31'd0, mem_done}, 32'd1);
      tick();

      // Never ack: read request that stalls
      MM = 1'b1; R_W = 1'b1; tick();
      MM = 1'b0; R_W = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 1; i < 15; i++) tick();
      chk("tmo_pre_req", {31'd0, mem_req}, 32'd1);
      chk("tmo_pre_err", {31'd0, bus_err}, 32'd0);
      tick();
      chk("tmo_done", {31'd0, mem_done}, 32'd1);
      chk("tmo_err",  {31'd0, bus_err},  32'd1);
      chk("tmo_mdr",  {16'd0, mem_wdata}, 32'h00AA);
      tick();
      chk("tmo_sticky", {31'd0, bus_err}, 32'd1);
      MM = 1'b1; R_W = 1'b1; tick();
      MM = 1'b0; R_W = 1'b0;
`else
      for (int i = 0; i < 20; i++) tick();
      chk("stall_req",  {31'd0, mem_req},  32'd1);
      chk("stall_err",  {31'd0, bus_err},  32'd0);
      chk("stall_done", {31'd0, mem_done}, 32'd0);
`endif

      // Reset mid-REQ: outputs drop without waiting for a clock edge
      chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1; #1;
      chk("mid_rst_req",  {31'd0, mem_req},   32'd0);
      chk("mid_rst_busy", {31'd0, busy},      32'd0);
      chk("mid_rst_done", {31'd0, mem_done},  32'd0);
      chk("mid_rst_mar",  {16'd0, mem_addr},  32'd0);
      chk("mid_rst_mdr",  {16'd0, mem_wdata}, 32'd0);
      chk("mid_rst_err",  {31'd0, bus_err},   32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_done", {31'd0, mem_done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
